// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-period math.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Clock cycles per serial bit; the remainder of the division is dropped.
    function automatic int unsigned calc_cpb(input int unsigned clock_hz,
                                             input int unsigned baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a start-edge reference, one-deep holding register
// with valid/ready handshake, and single-cycle frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CPB  = calc_cpb(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF = CPB / 2;
    localparam int          CW   = $clog2(CPB);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
    end

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rxs;
    logic          rxs_prev;
    logic          stop_sample;
    logic          stop_good;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rxd),
        .q  (rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            rxs_prev  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            rxs_prev  <= rxs;
        end
    end

    // NOTE: the shift register has no reset; every bit is overwritten before it is ever loaded out.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (rxs_prev && !rxs) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d   = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stop_good = stop_sample && rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_sample && !rxs;
            overrun   <= stop_good && rx_valid && !rx_ready;
            // A byte may load into a register that is being consumed in this same cycle.
            if (stop_good && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_data  output  8  received byte; stable while rx_valid is high.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts the byte when rx_valid and rx_ready are both high in a cycle.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: new byte completed while the previous byte was still unconsumed.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 CPB = CLOCK_FREQUENCY / BAUD_RATE (integer division) and HALF = CPB / 2; defaults give CPB=868 and HALF=434; CPB < 4 shall be an elaboration error.
REQ-013 rxd passes through a 2-FF synchronizer; only the synchronized value (rxs) is used internally.
REQ-014 States: IDLE, START, DATA, STOP; a single bit-period counter and a 3-bit bit index.
REQ-015 IDLE: a falling edge on rxs (previous 1, current 0) moves to START; the detection cycle is T0.
REQ-016 START: rxs sampled at T0+HALF; 0 -> DATA; 1 -> IDLE (glitch rejected, no error flag).
REQ-017 DATA: 8 samples, each CPB cycles after the previous sample, shifted in LSB first; after the 8th sample -> STOP.
REQ-018 STOP: sampled CPB cycles after the 8th data bit (T0+HALF+9*CPB), then -> IDLE in the next cycle.
REQ-019 Stop bit 1 with holding register free or being consumed in that same cycle: rx_data is loaded and rx_valid goes high one cycle after the stop sample (T0+HALF+9*CPB+1).
REQ-020 Stop bit 1 while rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data and rx_valid are unchanged, and overrun pulses one cycle after the stop sample.
REQ-021 Stop bit 0: the byte is discarded, rx_data and rx_valid are unchanged, and frame_err pulses one cycle after the stop sample.
REQ-022 rx_valid clears in the cycle after a handshake unless REQ-019 reloads it in that same cycle.
REQ-023 A line held low (break) produces at most one frame_err and no further starts until rxs returns high and falls again.
REQ-024 rx_ready is ignored while rx_valid=0.
REQ-025 Back-to-back frames with a single stop bit shall be received without loss at nominal baud (IDLE re-arms before the next start edge).

Reset
REQ-026 With rst high at a clock edge: state=IDLE, counters=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer FFs=1, edge-detect previous register=0.
REQ-027 Reset mid-frame aborts the frame with no flags; a start is only accepted after rxs has been seen high at least once post-reset.

Structure
REQ-028 Shared package uart_pkg holds the state enum and a CPB calculation function, so uart_tx can reuse them.
REQ-029 One sub-module, sync_2ff (parameterized reset value), holds the synchronizer; everything else stays in uart_rx.

Verification (bench parameters CLOCK_FREQUENCY=16, BAUD_RATE=1, giving CPB=16, HALF=8)
REQ-030 Send 0xA5 with stop=1 and rx_ready=1 -> rx_valid high for exactly 1 cycle, rx_data=0xA5, at T0+153.
REQ-031 Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> rx_data=0x3C held, overrun pulses once at the second frame's stop+1; then assert rx_ready -> rx_valid clears next cycle.
REQ-032 Send 0x55 with stop bit 0 -> frame_err pulses once, rx_valid stays 0; hold the line low for 40 bit times -> no further pulses, busy=0.
REQ-033 4-cycle low glitch on idle rxd -> return to IDLE, no rx_valid, frame_err or overrun.
REQ-034 Assert rst during bit 4 of 0xFF, release with rxd low, then send 0x81 -> no output for the aborted frame; 0x81 received correctly.
REQ-035 Second byte 0x12 completes in the same cycle a handshake takes 0x34 -> 0x12 loaded, rx_valid stays high, no overrun.
